gated_sr_sched: RTL and testbench

Sequencer and two-port arbiter for a single gated SR latch. Two requesters issue set/reset commands over a req/ack handshake. The block grants one requester at a time, round-robin. It then drives the latch's s, r and e inputs through a fixed setup / enable-pulse / hold sequence, so s and r never change while e is high and s=r=1 is never driven. It sits between the clocked control logic and the asynchronous latch primitive, and can optionally check the latch output after each write.

---
 rtl/gated_sr_sched.sv | 153 +++++++++++++++
 tb/tb_gated_sr_sched.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/gated_sr_sched.sv
// Purpose : round-robin two-port arbiter and setup/pulse/hold sequencer driving one gated SR latch.
// Latency : grant edge = cycle 0; ack in cycle PULSE_W+4 (SR_VERIFY_EN) or PULSE_W+3 (default).
// Backpressure: req/ack handshake; a requester holds req until its 1-cycle ack; next grant occurs in the ack cycle.
//
// Optional feature macro: SR_VERIFY_EN adds a CHECK state that compares q_in with the written value
// and reports the result on err in the ack cycle. Without it q_in is unused and err stays 0.
//
// Ports:
//   clk, rst_n           clock, synchronous active-low reset
//   req_a/cmd_a/ack_a    requester A handshake (cmd 1 = set, 0 = reset), ack is a 1-cycle pulse
//   req_b/cmd_b/ack_b    requester B handshake
//   q_in                 latch q fed back for readback
//   s_out/r_out/e_out    latch set / reset / enable
//   busy                 high whenever the sequencer is not IDLE
//   gnt_b                current or last granted requester (0 = A, 1 = B)
//   err                  readback mismatch, valid only in the ack cycle
//
// PULSE_W legal range is 1..255 (8-bit pulse counter).
module gated_sr_sched #(
  parameter int unsigned PULSE_W = 2
) (
  input  logic clk,
  input  logic rst_n,
  input  logic req_a,
  input  logic cmd_a,
  output logic ack_a,
  input  logic req_b,
  input  logic cmd_b,
  output logic ack_b,
  input  logic q_in,
  output logic s_out,
  output logic r_out,
  output logic e_out,
  output logic busy,
  output logic gnt_b,
  output logic err
);

`ifdef SR_VERIFY_EN
  typedef enum logic [2:0] {IDLE, SETUP, PULSE, HOLD, CHECK} state_t;
`else
  typedef enum logic [1:0] {IDLE, SETUP, PULSE, HOLD} state_t;
`endif

  localparam logic [7:0] PULSE_LOAD = 8'(PULSE_W - 1);

  state_t     state, state_nx;
  logic [7:0] cnt, cnt_nx;
  logic       cmd_r, cmd_nx;
  logic       gnt_nx;
  logic       ack_a_nx, ack_b_nx;
  logic       err_nx;
  logic       eff_a, eff_b, pick_b;
  logic       drive_nx;

`ifndef SR_VERIFY_EN
  // q_in has no consumer when readback is compiled out.
  logic unused_q;
  assign unused_q = q_in;
`endif

  // A requester whose ack is high this cycle is still holding req from the
  // finished write; it only counts as a new request from the next cycle.
  assign eff_a = req_a & ~ack_a;
  assign eff_b = req_b & ~ack_b;

  // B wins if it is the only requester, or on contention when A was granted last.
  assign pick_b = eff_b & (~eff_a | ~gnt_b);

  always_comb begin
    state_nx = state;
    cnt_nx   = cnt;
    cmd_nx   = cmd_r;
    gnt_nx   = gnt_b;
    ack_a_nx = 1'b0;
    ack_b_nx = 1'b0;
    err_nx   = 1'b0;

    case (state)
      IDLE: begin
        if (eff_a | eff_b) begin
          state_nx = SETUP;
          gnt_nx   = pick_b;
          cmd_nx   = pick_b ? cmd_b : cmd_a;
        end
      end
      SETUP: begin
        state_nx = PULSE;
        cnt_nx   = PULSE_LOAD;
      end
      PULSE: begin
        if (cnt == 8'd0) begin
          state_nx = HOLD;
        end else begin
          cnt_nx = cnt - 8'd1;
        end
      end
      HOLD: begin
`ifdef SR_VERIFY_EN
        state_nx = CHECK;
`else
        state_nx = IDLE;
        ack_a_nx = ~gnt_b;
        ack_b_nx = gnt_b;
`endif
      end
`ifdef SR_VERIFY_EN
      CHECK: begin
        state_nx = IDLE;
        ack_a_nx = ~gnt_b;
        ack_b_nx = gnt_b;
        err_nx   = q_in ^ cmd_r;
      end
`endif
      default: begin
        state_nx = IDLE;
      end
    endcase
  end

  // Outputs are decoded from the next state and registered, so each output
  // lines up with the state it belongs to and nothing is combinational from req/cmd.
  assign drive_nx = (state_nx == SETUP) || (state_nx == PULSE) || (state_nx == HOLD);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state <= IDLE;
      cnt   <= 8'd0;
      cmd_r <= 1'b0;
      gnt_b <= 1'b1;
      ack_a <= 1'b0;
      ack_b <= 1'b0;
      err   <= 1'b0;
      s_out <= 1'b0;
      r_out <= 1'b0;
      e_out <= 1'b0;
      busy  <= 1'b0;
    end else begin
      state <= state_nx;
      cnt   <= cnt_nx;
      cmd_r <= cmd_nx;
      gnt_b <= gnt_nx;
      ack_a <= ack_a_nx;
      ack_b <= ack_b_nx;
      err   <= err_nx;
      s_out <= drive_nx & cmd_nx;
      r_out <= drive_nx & ~cmd_nx;
      e_out <= (state_nx == PULSE);
      busy  <= (state_nx != IDLE);
    end
  end

endmodule

// File: tb/tb_gated_sr_sched.sv
// Purpose : directed self-checking bench for gated_sr_sched with a behavioural latch model.
// Latency : expectations derived from the grant edge (cycle 0) and PULSE_W.
// Backpressure: requesters hold req until ack, as the handshake requires.
module tb_gated_sr_sched;

`ifdef SR_VERIFY_EN
  localparam bit VERIFY = 1'b1;
  localparam int PW     = 2;
`else
  localparam bit VERIFY = 1'b0;
  localparam int PW     = 1;
`endif
  localparam int ACK = VERIFY ? PW + 4 : PW + 3;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic req_a = 1'b0, cmd_a = 1'b0, ack_a;
  logic req_b = 1'b0, cmd_b = 1'b0, ack_b;
  logic q_in;
  logic s_out, r_out, e_out, busy, gnt_b, err;

  logic latch_q = 1'b0;
  logic stuck_en = 1'b0;
  logic mon_en = 1'b0;
  logic prev_s = 1'b0, prev_r = 1'b0;

  int n_chk = 0;
  int n_fail = 0;

  gated_sr_sched #(.PULSE_W(PW)) dut (
    .clk(clk), .rst_n(rst_n),
    .req_a(req_a), .cmd_a(cmd_a), .ack_a(ack_a),
    .req_b(req_b), .cmd_b(cmd_b), .ack_b(ack_b),
    .q_in(q_in),
    .s_out(s_out), .r_out(r_out), .e_out(e_out),
    .busy(busy), .gnt_b(gnt_b), .err(err)
  );

  always #5 clk = ~clk;

  // Gated SR latch: transparent while e is high.
  always @(posedge clk) begin
    if (e_out) begin
      if (s_out) latch_q <= 1'b1;
      else if (r_out) latch_q <= 1'b0;
    end
  end
  assign q_in = stuck_en ? 1'b1 : latch_q;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
    end
  endtask

  // Per-cycle invariants on the latch interface and the acks.
  always @(negedge clk) begin
    if (mon_en) begin
      chk("never_s_and_r", s_out & r_out, 0);
      chk("ack_exclusive", ack_a & ack_b, 0);
      if (e_out) chk("sr_stable_while_e", {s_out, r_out}, {prev_s, prev_r});
    end
    prev_s = s_out;
    prev_r = r_out;
  end

  task automatic do_reset();
    @(posedge clk); #1;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
  endtask

  // One write from a single requester; checks every cycle from grant to just after ack.
  task automatic run_single(input bit use_b, input bit cmd, input bit exp_err, input bit drop_early);
    bit drv;
    @(posedge clk); #1;
    if (use_b) begin req_b = 1'b1; cmd_b = cmd; end
    else       begin req_a = 1'b1; cmd_a = cmd; end
    for (int k = 0; k <= ACK + 1; k++) begin
      @(negedge clk);
      drv = (k >= 1) && (k <= PW + 2);
      chk("s_out", s_out, drv & cmd);
      chk("r_out", r_out, drv & ~cmd);
      chk("e_out", e_out, (k >= 2) && (k <= PW + 1));
      chk("busy", busy, (k >= 1) && (k < ACK));
      chk("ack_granted", use_b ? ack_b : ack_a, k == ACK);
      chk("ack_other", use_b ? ack_a : ack_b, 0);
      chk("err", err, (k == ACK) & exp_err);
      if (k == 1) begin
        chk("gnt_b", gnt_b, use_b);
        // a command change after grant must not affect the write
        if (use_b) cmd_b = ~cmd; else cmd_a = ~cmd;
      end
      if ((drop_early && k == 2) || k == ACK) begin
        if (use_b) req_b = 1'b0; else req_a = 1'b0;
      end
    end
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, n_fail %0d", n_fail);
    $fatal(1, "watchdog expired");
  end

  initial begin
    // Reset state
    @(posedge clk); #1;
    @(negedge clk);
    chk("rst_s_out", s_out, 0);
    chk("rst_r_out", r_out, 0);
    chk("rst_e_out", e_out, 0);
    chk("rst_ack_a", ack_a, 0);
    chk("rst_ack_b", ack_b, 0);
    chk("rst_busy", busy, 0);
    chk("rst_err", err, 0);
    chk("rst_gnt_b", gnt_b, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    mon_en = 1'b1;

    // Single set from A, latch follows so readback matches.
    run_single(1'b0, 1'b1, 1'b0, 1'b0);

    // Both requesters from reset, held: A, B, A, B with grant in each ack cycle.
    do_reset();
    @(posedge clk); #1;
    req_a = 1'b1; cmd_a = 1'b1;
    req_b = 1'b1; cmd_b = 1'b0;
    for (int k = 0; k <= 4 * ACK; k++) begin
      @(negedge clk);
      chk("rr_ack_a", ack_a, (k == ACK) || (k == 3 * ACK));
      chk("rr_ack_b", ack_b, (k == 2 * ACK) || (k == 4 * ACK));
      if (k == ACK || k == 2 * ACK || k == 3 * ACK || k == 4 * ACK)
        chk("rr_err", err, 0);
      for (int m = 0; m < 4; m++) begin
        if (k == 1 + m * ACK) begin
          chk("rr_gnt_b", gnt_b, m % 2);
          chk("rr_s_setup", s_out, (m % 2) == 0);
          chk("rr_r_setup", r_out, (m % 2) == 1);
          chk("rr_busy", busy, 1);
        end
      end
      if (k == 4 * ACK) begin req_a = 1'b0; req_b = 1'b0; end
    end
    @(negedge clk);
    chk("rr_idle_busy", busy, 0);

    // Reset from B with q_in stuck high: mismatch flagged only when readback is built in.
    stuck_en = 1'b1;
    run_single(1'b1, 1'b0, VERIFY, 1'b0);
    stuck_en = 1'b0;

    // Reset asserted during PULSE aborts without an ack.
    @(posedge clk); #1;
    req_a = 1'b1; cmd_a = 1'b0;
    for (int k = 0; k <= 2; k++) @(negedge clk);
    chk("abort_in_pulse", e_out, 1);
    rst_n = 1'b0;
    @(negedge clk);
    req_a = 1'b0;
    chk("abort_s_out", s_out, 0);
    chk("abort_r_out", r_out, 0);
    chk("abort_e_out", e_out, 0);
    chk("abort_busy", busy, 0);
    chk("abort_ack_a", ack_a, 0);
    chk("abort_err", err, 0);
    chk("abort_gnt_b", gnt_b, 1);
    @(posedge clk); #1 rst_n = 1'b1;
    for (int k = 0; k < ACK + 2; k++) begin
      @(negedge clk);
      chk("abort_no_ack", ack_a, 0);
    end

    // A later request is served normally, even with req dropped after grant.
    run_single(1'b0, 1'b1, 1'b0, 1'b1);

    repeat (2) @(negedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
